song_sequencer: RTL
===================

Name: song_sequencer

Overview:
Parametrised note sequencer that plays a song from a ROM preloaded by file. Each ROM word carries a note code and a duration in beats. A programmable beat prescaler sets tempo. Adds start/stop/pause control, one-shot or loop mode, an optional articulation rest between notes, and an end-of-song marker. Sits between the song ROM data and the tone generator, driving its note code.

Parameters:
NOTE_W, 7, width of note code; code 0 = rest (silence)
DUR_W, 4, width of per-note duration field in beats; duration 0 = end-of-song marker
DEPTH, 48, number of ROM words
TICKS_PER_BEAT, 12500000, clk cycles per beat (>=1)
GAP_TICKS, 0, clk cycles of rest inserted after each note (0 = legato)
SONG_FILE, "merrychristmas.mem", binary init file; word = {dur[DUR_W-1:0], note[NOTE_W-1:0]}

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level-sampled; begins playback from index 0 (restarts if already playing)
stop  in  1  aborts playback and returns to IDLE
pause  in  1  while high, all counters freeze and the note is held
loop_en  in  1  1 = wrap to index 0 at end of song; 0 = one-shot
note  out  NOTE_W  current note code (registered)
note_strobe  out  1  one-cycle pulse when a new ROM note is presented on note
playing  out  1  high in PLAY or GAP
done  out  1  high in DONE (one-shot completion) until start or stop
index  out  $clog2(DEPTH)  current ROM index

Behaviour:
- Reset (async): state=IDLE, note=0, note_strobe=0, playing=0, done=0, index=0, beat and duration counters=0.
- States: IDLE, PLAY, GAP, DONE. All transitions occur on clk rising edge.
- Priority per cycle: stop > start > pause > normal advance.
- stop in any state -> IDLE next edge; note=0, done=0, index=0.
- start (stop low) in any state: if ROM[0].dur==0 -> DONE with note=0, no strobe. Otherwise -> PLAY, index=0, note=ROM[0].note, note_strobe=1, beat counter cleared, remaining beats = ROM[0].dur.
- PLAY: beat counter counts 0..TICKS_PER_BEAT-1; at terminal count it decrements remaining. After exactly dur*TICKS_PER_BEAT cycles in PLAY:
  - GAP_TICKS>0: -> GAP, note=0, for exactly GAP_TICKS cycles.
  - GAP_TICKS=0: advance directly.
- Advance: candidate = index+1, or 0 if index==DEPTH-1.
  - If candidate wrapped, or ROM[candidate].dur==0 (end marker):
    - loop_en=1: index=0 and play ROM[0] (strobe).
    - loop_en=0: -> DONE, note=0, index holds the last played note.
  - Else: index=candidate, note=ROM[candidate].note, note_strobe=1.
- Note period: each note occupies exactly dur*TICKS_PER_BEAT + GAP_TICKS cycles, strobe to strobe.
- pause: freezes beat, duration and gap counters, state and outputs; no strobe while paused. Resuming continues with no lost or extra cycles.
- loop_en is sampled only at the advance decision.
- DONE holds until start or stop. IDLE outputs note=0.
- Note code 0 in ROM is a legal rest that occupies its duration and strobes like any note.
- Counter widths: beat counter $clog2(TICKS_PER_BEAT+1); gap counter $clog2(GAP_TICKS+1). No overflow is possible.
- ROM is read asynchronously (combinational index into array). A synchronous-read variant must preserve the cycle behaviour above.

Decomposition:
- song_pkg: REST_NOTE=0, state enum {IDLE,PLAY,GAP,DONE}, word field slice helpers for {dur,note}.
- Sub-module beat_timer: TICKS_PER_BEAT prescaler with clear and enable, emitting a one-cycle beat pulse. The FSM, ROM and index logic stay in song_sequencer.

Test Plan:
- Test parameters: TICKS_PER_BEAT=4, GAP_TICKS=0, ROM={dur1 note10, dur2 note20, dur0}, loop_en=0.
  Stimulus: start pulse.
  Required: note=10 for 4 cycles, then 20 for 8 cycles, then DONE with note=0. Exactly 2 strobes; index ends at 1.
- Same ROM, loop_en=1.
  Required: sequence 10,20,10,20…; strobe period pattern 4,8,4,8; done never set.
- GAP_TICKS=2, same ROM.
  Required: note 10 x4, 0 x2, 20 x8, 0 x2, then DONE; strobe-to-strobe spacing 6 cycles.
- Pause high for 5 cycles, 2 cycles into note 20.
  Required: note 20 total hold = 8 + 5 cycles; no strobe during pause; following timing unchanged.
- Mid-note stop and start asserted together.
  Required: IDLE next cycle, note=0, index=0. A later start alone restarts at note 10 with strobe.
- ROM[0].dur=0; start.
  Required: DONE next cycle, note=0, no strobe. Separately, async reset mid-note clears all outputs without a clock edge.

Source files
------------

// File: rtl/song_pkg.sv
// ---------------------------------------------------------------------------
// song_pkg
// Shared definitions for the song sequencer: the rest note code, the player
// state encoding and helpers that split a song word {dur, note} into fields.
// No ports (package).
// ---------------------------------------------------------------------------
package song_pkg;

  // A note code of zero is silence, both in the ROM and on the output.
  localparam int REST_NOTE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Plain-vector aliases of the state encoding for legacy-style FSM code.
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_PLAY = PLAY;
  localparam logic [1:0] ST_GAP  = GAP;
  localparam logic [1:0] ST_DONE = DONE;

  // Low noteW bits of a song word hold the note code.
  function automatic logic [31:0] wordNote(input logic [31:0] word, input int noteW);
    return word & ((32'd1 << noteW) - 32'd1);
  endfunction

  // The durW bits above the note code hold the duration in beats.
  function automatic logic [31:0] wordDur(input logic [31:0] word, input int noteW,
                                          input int durW);
    return (word >> noteW) & ((32'd1 << durW) - 32'd1);
  endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// ---------------------------------------------------------------------------
// song_sequencer_if
// Control and note bus between a controller/testbench (master) and the
// song sequencer (slave).
//   start, stop, pause, loop_en : master -> sequencer controls
//   note, note_strobe           : current note code and new-note pulse
//   playing, done, index        : player status and current ROM index
// ---------------------------------------------------------------------------
interface song_sequencer_if #(
  parameter int NOTE_W = 7,
  parameter int DEPTH  = 48
);
  localparam int INDEX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic               start;
  logic               stop;
  logic               pause;
  logic               loop_en;
  logic [NOTE_W-1:0]  note;
  logic               note_strobe;
  logic               playing;
  logic               done;
  logic [INDEX_W-1:0] index;

  modport master (
    output start, stop, pause, loop_en,
    input  note, note_strobe, playing, done, index
  );

  modport slave (
    input  start, stop, pause, loop_en,
    output note, note_strobe, playing, done, index
  );
endinterface

// File: rtl/song_sequencer_beat_timer.sv
// ---------------------------------------------------------------------------
// beat_timer
// Tempo prescaler: counts enabled clk cycles 0..TICKS_PER_BEAT-1 and pulses
// o_beat during the last count of every beat.
//   clk, reset : clock, asynchronous active-high reset
//   i_clear    : restart the beat from count 0 (wins over i_enable)
//   i_enable   : advance the count; low freezes it
//   o_beat     : one-cycle pulse on the terminal count while enabled
// ---------------------------------------------------------------------------
module beat_timer #(
  parameter int TICKS_PER_BEAT = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_beat
);

  localparam int CW = $clog2(TICKS_PER_BEAT + 1);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_BEAT - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);
  assign o_beat = i_enable && w_last;

  // Count wraps to zero on the terminal count so the next beat starts cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_last ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
// Plays a song held in a constant ROM of {dur, note} words. Each note is held
// for dur beats, optionally followed by GAP_TICKS cycles of rest, then the
// next word is presented. A word with dur == 0 (or running off the ROM end)
// ends the song: wrap to word 0 when loop_en is high, otherwise stop in DONE.
// ROM contents come from ROM_INIT, word i at bits [i*W +: W].
//   clk, reset : clock, asynchronous active-high reset
//   bus        : song_sequencer_if slave (start/stop/pause/loop_en in,
//                note/note_strobe/playing/done/index out)
// ---------------------------------------------------------------------------
module song_sequencer
  import song_pkg::*;
#(
  parameter int NOTE_W         = 7,
  parameter int DUR_W          = 4,
  parameter int DEPTH          = 48,
  parameter int TICKS_PER_BEAT = 12500000,
  parameter int GAP_TICKS      = 0,
  parameter logic [DEPTH*(NOTE_W+DUR_W)-1:0] ROM_INIT = '0
) (
  input  logic            clk,
  input  logic            reset,
  song_sequencer_if.slave bus
);

  localparam int W  = NOTE_W + DUR_W;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  logic [1:0]        r_state;
  logic [NOTE_W-1:0] r_note;
  logic              r_strobe;
  logic [IW-1:0]     r_index;
  logic [DUR_W-1:0]  r_remain;
  logic [GW-1:0]     r_gapCnt;

  logic [W-1:0]      w_rom [DEPTH];
  logic [NOTE_W-1:0] w_note0;
  logic [DUR_W-1:0]  w_dur0;
  logic              w_wrap;
  logic [IW-1:0]     w_cand;
  logic              w_candEnd;
  logic [IW-1:0]     w_nextIdx;
  logic [NOTE_W-1:0] w_nextNote;
  logic [DUR_W-1:0]  w_nextDur;
  logic              w_beat;
  logic              w_noteEnd;
  logic              w_advance;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign w_rom[g] = ROM_INIT[g*W +: W];
  end

  assign w_note0 = NOTE_W'(wordNote(32'(w_rom[0]), NOTE_W));
  assign w_dur0  = DUR_W'(wordDur(32'(w_rom[0]), NOTE_W, DUR_W));

  // End of song is either running past the last word or hitting a dur==0 marker;
  // both resolve to word 0, which is only played when looping.
  assign w_wrap     = (r_index == LAST_IDX);
  assign w_cand     = w_wrap ? '0 : r_index + IW'(1);
  assign w_candEnd  = w_wrap || (wordDur(32'(w_rom[w_cand]), NOTE_W, DUR_W) == 32'd0);
  assign w_nextIdx  = w_candEnd ? '0 : w_cand;
  assign w_nextNote = NOTE_W'(wordNote(32'(w_rom[w_nextIdx]), NOTE_W));
  assign w_nextDur  = DUR_W'(wordDur(32'(w_rom[w_nextIdx]), NOTE_W, DUR_W));

  beat_timer #(
    .TICKS_PER_BEAT (TICKS_PER_BEAT)
  ) u_beat_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (bus.start || bus.stop),
    .i_enable ((r_state == ST_PLAY) && !bus.pause),
    .o_beat   (w_beat)
  );

  // The note's last beat either opens the gap or, in legato, advances at once.
  assign w_noteEnd = w_beat && (r_remain == DUR_W'(1));
  assign w_advance = (GAP_TICKS == 0) ? w_noteEnd
                                      : ((r_state == ST_GAP) && (r_gapCnt == GAP_LAST));

  // Player FSM: stop beats start beats pause; pause freezes every counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_note   <= NOTE_W'(REST_NOTE);
      r_strobe <= 1'b0;
      r_index  <= '0;
      r_remain <= '0;
      r_gapCnt <= '0;
    end else begin
      r_strobe <= 1'b0;
      if (bus.stop) begin
        r_state  <= ST_IDLE;
        r_note   <= NOTE_W'(REST_NOTE);
        r_index  <= '0;
        r_remain <= '0;
        r_gapCnt <= '0;
      end else if (bus.start) begin
        r_index  <= '0;
        r_gapCnt <= '0;
        if (w_dur0 == '0) begin
          r_state  <= ST_DONE;
          r_note   <= NOTE_W'(REST_NOTE);
          r_remain <= '0;
        end else begin
          r_state  <= ST_PLAY;
          r_note   <= w_note0;
          r_strobe <= 1'b1;
          r_remain <= w_dur0;
        end
      end else if (!bus.pause) begin
        if (w_advance) begin
          if (w_candEnd && !bus.loop_en) begin
            r_state <= ST_DONE;
            r_note  <= NOTE_W'(REST_NOTE);
          end else begin
            r_state  <= ST_PLAY;
            r_index  <= w_nextIdx;
            r_note   <= w_nextNote;
            r_strobe <= 1'b1;
            r_remain <= w_nextDur;
          end
        end else if (w_noteEnd) begin
          r_state  <= ST_GAP;
          r_note   <= NOTE_W'(REST_NOTE);
          r_gapCnt <= '0;
        end else if (r_state == ST_GAP) begin
          r_gapCnt <= r_gapCnt + GW'(1);
        end else if (w_beat) begin
          r_remain <= r_remain - DUR_W'(1);
        end
      end
    end
  end

  assign bus.note        = r_note;
  assign bus.note_strobe = r_strobe;
  assign bus.playing     = (r_state == ST_PLAY) || (r_state == ST_GAP);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.index       = r_index;

endmodule
